cordic_fix2float: RTL and testbench

Pipelined fixed-point to IEEE-754 single-precision converter that sits directly downstream of the rolled CORDIC cosine pipeline. It takes the CORDIC's signed fixed-point result, plus a quadrant negate flag from the range-reduction logic, and produces a 32-bit float. It also carries a valid bit alongside the data so downstream float units can accept results with a handshake.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_lzc.sv | 21 ++
 rtl/cordic_fix2float.sv | 108 ++++++++++
 tb/tb_cordic_fix2float.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC datapath and its float output stage.
package cordic_pkg;

  localparam int CORDIC_WIDTH = 22;
  localparam int CORDIC_FRAC  = 20;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exponent;
    logic [FP_MANT_W-1:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/cordic_lzc.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module cordic_lzc #(
  parameter int WIDTH = 22
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [4:0]       lead_pos,
  output logic             all_zero
);

  always_comb begin
    lead_pos = '0;
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (data_in[i]) begin
        lead_pos = 5'(i);
      end
    end
    all_zero = ~|data_in;
  end

endmodule

// File: rtl/cordic_fix2float.sv
// Three-stage signed fixed-point to IEEE-754 single converter with a valid chain.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int WIDTH     = CORDIC_WIDTH,
  parameter int FRAC_BITS = CORDIC_FRAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] fix_in,
  input  logic             neg_in,
  output logic             out_valid,
  output logic [31:0]      float_out
);

  logic             v1_q, v1_d, sign1_q, sign1_d, zero1_q, zero1_d;
  logic [WIDTH-1:0] mag1_q, mag1_d;
  logic             v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [WIDTH-1:0] mag2_q, mag2_d;
  logic [4:0]       pos2_q, pos2_d;
  logic             v3_q, v3_d;
  fp32_t            float_q, float_d;

  logic [4:0]       lzc_pos;
  logic             lzc_zero;
  logic [23:0]      mant_ext;
  fp32_t            packed_fp;

  cordic_lzc #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .data_in (mag1_q),
    .lead_pos(lzc_pos),
    .all_zero(lzc_zero)
  );

  always_comb begin
    // Shifting bit p up to bit 23 leaves the fraction in [22:0].
    mant_ext           = 24'(mag2_q) << (5'd23 - pos2_q);
    packed_fp.sign     = sign2_q;
    packed_fp.exponent = FP_EXP_W'(FP_BIAS + int'(pos2_q) - FRAC_BITS);
    packed_fp.mantissa = mant_ext[FP_MANT_W-1:0];
  end

  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    zero1_d = zero1_q;
    mag1_d  = mag1_q;
    v2_d    = v2_q;
    sign2_d = sign2_q;
    zero2_d = zero2_q;
    mag2_d  = mag2_q;
    pos2_d  = pos2_q;
    v3_d    = v3_q;
    float_d = float_q;
    if (enable) begin
      v1_d    = in_valid;
      sign1_d = fix_in[WIDTH-1] ^ neg_in;
      zero1_d = (fix_in == '0);
      // WIDTH-bit negate maps the most negative code to 2^(WIDTH-1) unsigned.
      mag1_d  = fix_in[WIDTH-1] ? (~fix_in + 1'b1) : fix_in;

      v2_d    = v1_q;
      sign2_d = sign1_q;
      zero2_d = zero1_q | lzc_zero;
      mag2_d  = mag1_q;
      pos2_d  = lzc_pos;

      v3_d    = v2_q;
      float_d = zero2_q ? fp32_t'('0) : packed_fp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      mag2_q  <= '0;
      pos2_q  <= '0;
      v3_q    <= 1'b0;
      float_q <= '0;
    end else begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      zero1_q <= zero1_d;
      mag1_q  <= mag1_d;
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      mag2_q  <= mag2_d;
      pos2_q  <= pos2_d;
      v3_q    <= v3_d;
      float_q <= float_d;
    end
  end

  assign out_valid = v3_q;
  assign float_out = float_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Scoreboard bench for cordic_fix2float: directed samples with hand-computed float results.
module tb_cordic_fix2float;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic [21:0] fix_in = '0;
  logic        neg_in = 1'b0;
  logic        out_valid;
  logic [31:0] float_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  cordic_fix2float #(
    .WIDTH    (22),
    .FRAC_BITS(20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .fix_in   (fix_in),
    .neg_in   (neg_in),
    .out_valid(out_valid),
    .float_out(float_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample for the coming edge; expected result is hand-computed by the caller.
  task automatic send(input logic [21:0] fix, input logic neg, input logic [31:0] expv);
    in_valid = 1'b1;
    fix_in   = fix;
    neg_in   = neg;
    if (enable && !reset) exp_q.push_back(expv);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    fix_in   = '0;
    neg_in   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops one expectation per enabled edge that presents a valid result.
  always begin
    logic en_s, rst_s;
    logic [31:0] e;
    @(posedge clk);
    en_s  = enable;
    rst_s = reset;
    #1;
    if (en_s && !rst_s && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("float_out", float_out, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_float", float_out, 32'h0);
    reset = 1'b0;
    idle(1);

    send(22'h100000, 1'b0, 32'h3F800000);
    idle(3);
    check("latency_valid_low", 32'(out_valid), 32'd0);

    send(22'h080000, 1'b0, 32'h3F000000);
    send(22'h1FFFFF, 1'b0, 32'h3FFFFFF8);
    send(22'h000001, 1'b0, 32'h35800000);
    send(22'h300000, 1'b0, 32'hBF800000);
    send(22'h200000, 1'b0, 32'hC0000000);
    send(22'h100000, 1'b1, 32'hBF800000);
    send(22'h300000, 1'b1, 32'h3F800000);
    send(22'h000000, 1'b1, 32'h00000000);
    drain();
    idle(2);

    // Stall mid-stream: after 3 sends the output shows the first sample.
    send(22'h100000, 1'b0, 32'h3F800000);
    send(22'h080000, 1'b0, 32'h3F000000);
    send(22'h300000, 1'b0, 32'hBF800000);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      fix_in   = 22'h0ABCDE;
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_float", float_out, 32'h3F800000);
    end
    enable = 1'b1;
    send(22'h1FFFFF, 1'b0, 32'h3FFFFFF8);
    send(22'h000001, 1'b0, 32'h35800000);
    drain();
    idle(2);

    // Bubble pattern 1,0,1.
    send(22'h080000, 1'b0, 32'h3F000000);
    idle(1);
    send(22'h200000, 1'b1, 32'h40000000);
    in_valid = 1'b0;
    check("bubble_v0", 32'(out_valid), 32'd1);
    step();
    check("bubble_v1", 32'(out_valid), 32'd0);
    step();
    check("bubble_v2", 32'(out_valid), 32'd1);
    drain();
    idle(2);

    // Reset with two samples in flight; they must never emerge.
    send(22'h100000, 1'b0, 32'h3F800000);
    send(22'h1FFFFF, 1'b0, 32'h3FFFFFF8);
    in_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    step();
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_float", float_out, 32'h0);
    reset = 1'b0;
    idle(6);
    check("post_reset_valid", 32'(out_valid), 32'd0);
    check("post_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
